// File: rtl/pixel_pkg.sv
// Shared definitions for the frame-buffer pixel path (packer and reader).
//   PIXEL_W / WORD_W         : pixel and memory word widths
//   DEF_ADDR_W / DEF_MAX_WORDS : default memory geometry
//   state_e                  : packer state encoding
package pixel_pkg;

    localparam int PIXEL_W       = 24;
    localparam int WORD_W        = 48;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_MAX_WORDS = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIRST  = 3'd1,
        SECOND = 3'd2,
        WRITE  = 3'd3,
        STROBE = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/pixel_packer.sv
// Packs two 24-bit RGB pixels per 48-bit word and writes each word to the
// pixel RAM with a setup cycle, a MEM_CLK strobe cycle and a release cycle.
// First pixel lands in [47:24], second in [23:0].
//
// Ports:
//   CLK, RESET            : clock, synchronous active-high reset
//   INTERFACE_EN          : starts a frame from IDLE, gates pixel acceptance
//   RGB_IN, PIXEL_VALID   : pixel source side of the valid/ready handshake
//   FLUSH                 : ends the frame early, odd pixel zero-padded
//   PIXEL_READY           : handshake ready (only combinational output)
//   DATA_OUT, MEM_ADDR    : word and address presented to the RAM
//   MEM_WE, MEM_CLK       : RAM write enable and write strobe
//   FRAME_DONE            : one-cycle end-of-frame pulse
//
// state  | meaning
// IDLE   | waiting for INTERFACE_EN
// FIRST  | waiting for the high-half pixel
// SECOND | waiting for the low-half pixel
// WRITE  | address/data setup, MEM_WE high
// STROBE | MEM_CLK high
// NEXT   | write released, advance address or finish
// DONE   | FRAME_DONE pulse, address rewinds
module pixel_packer
    import pixel_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                INTERFACE_EN,
    input  logic [PIXEL_W-1:0]  RGB_IN,
    input  logic                PIXEL_VALID,
    input  logic                FLUSH,
    output logic                PIXEL_READY,
    output logic [WORD_W-1:0]   DATA_OUT,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    output logic                MEM_WE,
    output logic                MEM_CLK,
    output logic                FRAME_DONE
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                flush_q, flush_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        flush_d = flush_q;

        case (state_q)
            IDLE: begin
                if (INTERFACE_EN) state_d = FIRST;
            end

            // With INTERFACE_EN low the whole state is frozen, FLUSH included.
            FIRST: begin
                if (INTERFACE_EN) begin
                    if (PIXEL_VALID) begin
                        data_d = {RGB_IN, {PIXEL_W{1'b0}}};
                        if (FLUSH) begin
                            flush_d = 1'b1;
                            state_d = WRITE;
                        end else begin
                            state_d = SECOND;
                        end
                    end else if (FLUSH) begin
                        state_d = DONE;
                    end
                end
            end

            SECOND: begin
                if (INTERFACE_EN) begin
                    if (PIXEL_VALID) begin
                        data_d[PIXEL_W-1:0] = RGB_IN;
                        flush_d             = FLUSH;
                        state_d             = WRITE;
                    end else if (FLUSH) begin
                        flush_d = 1'b1;
                        state_d = WRITE;
                    end
                end
            end

            WRITE:  state_d = STROBE;
            STROBE: state_d = NEXT;

            NEXT: begin
                if (addr_q == LAST_ADDR || flush_q) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = FIRST;
                end
            end

            DONE: begin
                addr_d  = '0;
                flush_d = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign PIXEL_READY = ((state_q == FIRST) || (state_q == SECOND)) && INTERFACE_EN;
    assign MEM_WE      = (state_q == WRITE) || (state_q == STROBE);
    assign MEM_CLK     = (state_q == STROBE);
    assign FRAME_DONE  = (state_q == DONE);
    assign DATA_OUT    = data_q;
    assign MEM_ADDR    = addr_q;

endmodule

// File: tb/tb_pixel_packer.sv
module tb_pixel_packer;
    import pixel_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int MW = DEF_MAX_WORDS;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              INTERFACE_EN;
    logic [23:0]       RGB_IN;
    logic              PIXEL_VALID;
    logic              FLUSH;
    logic              PIXEL_READY;
    logic [47:0]       DATA_OUT;
    logic [AW-1:0]     MEM_ADDR;
    logic              MEM_WE;
    logic              MEM_CLK;
    logic              FRAME_DONE;

    int tests      = 0;
    int fails      = 0;
    int cyc        = 0;
    int done_cnt   = 0;
    int strobe_run = 0;

    logic [AW+47:0] cap_q[$];
    logic [AW+47:0] exp_q[$];
    logic [23:0]    pix_q[$];

    pixel_packer #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .INTERFACE_EN (INTERFACE_EN),
        .RGB_IN       (RGB_IN),
        .PIXEL_VALID  (PIXEL_VALID),
        .FLUSH        (FLUSH),
        .PIXEL_READY  (PIXEL_READY),
        .DATA_OUT     (DATA_OUT),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_WE       (MEM_WE),
        .MEM_CLK      (MEM_CLK),
        .FRAME_DONE   (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Memory-side monitor: record every strobed write, check strobe shape.
    always @(negedge CLK) begin
        if (FRAME_DONE === 1'b1) done_cnt++;
        if (MEM_CLK === 1'b1) begin
            strobe_run++;
            check("we_during_strobe", 64'(MEM_WE), 64'd1);
            if (strobe_run == 1) cap_q.push_back({MEM_ADDR, DATA_OUT});
        end else if (strobe_run != 0) begin
            check("strobe_width", 64'(strobe_run), 64'd1);
            strobe_run = 0;
        end
    end

    task automatic send(input logic [23:0] p, input bit fl, input int gap, output int acc_cyc);
        repeat (gap) @(negedge CLK);
        RGB_IN      = p;
        PIXEL_VALID = 1'b1;
        FLUSH       = fl;
        acc_cyc     = -1;
        for (int i = 0; i < 100; i++) begin
            if (PIXEL_READY === 1'b1) begin
                acc_cyc = cyc + 1;
                @(negedge CLK);
                break;
            end
            @(negedge CLK);
        end
        PIXEL_VALID = 1'b0;
        FLUSH       = 1'b0;
        check("pixel_accepted", 64'(acc_cyc >= 0), 64'd1);
        pix_q.push_back(p);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (PIXEL_READY === 1'b1) break;
            @(negedge CLK);
        end
        check("ready_seen", 64'(PIXEL_READY), 64'd1);
    endtask

    // Reference: pixels pair up in arrival order, odd tail zero-padded,
    // word k goes to address k.
    task automatic build_expected();
        int n;
        logic [23:0] lo;
        n = pix_q.size();
        for (int i = 0; i < n; i += 2) begin
            lo = (i + 1 < n) ? pix_q[i+1] : 24'h0;
            exp_q.push_back({AW'(i / 2), pix_q[i], lo});
        end
    endtask

    task automatic compare_writes(input string tag);
        int n;
        build_expected();
        check({tag, "_write_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({tag, "_write"}, 64'(cap_q[i]), 64'(exp_q[i]));
        cap_q.delete();
        exp_q.delete();
        pix_q.delete();
    endtask

    task automatic end_frame(input string tag, input bit do_flush);
        int d0;
        d0 = done_cnt;
        if (do_flush) begin
            wait_ready();
            FLUSH = 1'b1;
            @(negedge CLK);
            FLUSH = 1'b0;
        end
        for (int i = 0; i < 60; i++) begin
            if (FRAME_DONE === 1'b1) break;
            @(negedge CLK);
        end
        check({tag, "_done_seen"}, 64'(FRAME_DONE), 64'd1);
        @(negedge CLK);
        check({tag, "_addr_rewound"}, 64'(MEM_ADDR), 64'd0);
        check({tag, "_idle_not_ready"}, 64'(PIXEL_READY), 64'd0);
        repeat (3) @(negedge CLK);
        check({tag, "_done_once"}, 64'(done_cnt), 64'(d0 + 1));
        compare_writes(tag);
    endtask

    initial begin
        int a0, a1, d0;
        logic [23:0] p1;

        RESET        = 1'b1;
        INTERFACE_EN = 1'b0;
        RGB_IN       = '0;
        PIXEL_VALID  = 1'b0;
        FLUSH        = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_ready", 64'(PIXEL_READY), 64'd0);
        check("rst_we",    64'(MEM_WE),      64'd0);
        check("rst_clk",   64'(MEM_CLK),     64'd0);
        check("rst_done",  64'(FRAME_DONE),  64'd0);
        check("rst_addr",  64'(MEM_ADDR),    64'd0);
        check("rst_data",  64'(DATA_OUT),    64'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("idle_en_low_ready", 64'(PIXEL_READY), 64'd0);

        // Back-to-back pair, then FLUSH in FIRST with no pixel: no extra write.
        INTERFACE_EN = 1'b1;
        send(24'h112233, 1'b0, 0, a0);
        send(24'h445566, 1'b0, 0, a1);
        check("second_accept_latency", 64'(a1 - a0), 64'd1);
        wait_ready();
        check("ready_return_latency", 64'(cyc + 1 - a0), 64'd5);
        end_frame("pair", 1'b1);

        // Full frame of random pixels with random gaps.
        for (int i = 0; i < 2 * MW; i++)
            send(24'($urandom()), 1'b0, int'($urandom_range(0, 2)), a0);
        end_frame("full", 1'b0);

        // Odd tail 0xABCDEF at address 3, flushed from SECOND.
        for (int i = 0; i < 6; i++)
            send(24'($urandom()), 1'b0, int'($urandom_range(0, 1)), a0);
        send(24'hABCDEF, 1'b0, 0, a0);
        end_frame("odd_flush", 1'b1);

        // Pixel and FLUSH together in FIRST.
        send(24'h010203, 1'b1, 0, a0);
        end_frame("flush_with_pixel", 1'b0);

        // INTERFACE_EN low for 4 cycles while holding the first pixel.
        p1 = 24'($urandom());
        send(p1, 1'b0, 0, a0);
        INTERFACE_EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("paused_ready", 64'(PIXEL_READY), 64'd0);
            check("paused_hold",  64'(DATA_OUT[47:24]), 64'(p1));
        end
        INTERFACE_EN = 1'b1;
        send(24'($urandom()), 1'b0, 1, a0);
        end_frame("pause", 1'b1);

        // RESET during the strobe of the word at address 7.
        d0 = done_cnt;
        for (int i = 0; i < 16; i++)
            send(24'($urandom()), 1'b0, int'($urandom_range(0, 1)), a0);
        check("rst_mid_setup_we",   64'(MEM_WE),   64'd1);
        check("rst_mid_setup_clk",  64'(MEM_CLK),  64'd0);
        check("rst_mid_setup_addr", 64'(MEM_ADDR), 64'd7);
        @(negedge CLK);
        check("rst_mid_strobe", 64'(MEM_CLK), 64'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("rst_mid_we",   64'(MEM_WE),     64'd0);
        check("rst_mid_clk",  64'(MEM_CLK),    64'd0);
        check("rst_mid_addr", 64'(MEM_ADDR),   64'd0);
        check("rst_mid_done", 64'(FRAME_DONE), 64'd0);
        repeat (3) @(negedge CLK);
        check("rst_mid_no_done", 64'(done_cnt), 64'(d0));
        compare_writes("rst_mid");

        // Next frame restarts at address 0.
        send(24'($urandom()), 1'b0, 0, a0);
        send(24'($urandom()), 1'b0, 0, a0);
        send(24'($urandom()), 1'b0, 0, a0);
        end_frame("after_rst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Write-side counterpart of the frame-buffer pixel reader. Accepts 24-bit RGB pixels over a valid/ready handshake and packs two per 48-bit memory word.
- Writes each word to the pixel memory with a strobed MEM_CLK and an incrementing word address. The first pixel goes to bits [47:24] and the second to [23:0], matching the order the reader unpacks them.
- Sits between the pixel source (camera/generator) and the dual-port pixel RAM.

Parameters:
- ADDR_W, 5, width of MEM_ADDR.
- MAX_WORDS, 32, number of 48-bit words per frame. Must be ≤ 2^ADDR_W. The last address written is MAX_WORDS-1.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- INTERFACE_EN  in  1  high starts a frame from IDLE and allows pixel acceptance; low pauses acceptance.
- RGB_IN  in  24  input pixel.
- PIXEL_VALID  in  1  RGB_IN is valid this cycle.
- FLUSH  in  1  ends the frame early; a pending odd pixel is padded with zeros.
- PIXEL_READY  out  1  the block accepts a pixel this cycle.
- DATA_OUT  out  48  packed word to memory.
- MEM_ADDR  out  ADDR_W  word address.
- MEM_WE  out  1  memory write enable.
- MEM_CLK  out  1  memory write strobe.
- FRAME_DONE  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset:
  - One clock is enough: state=IDLE, MEM_ADDR=0, DATA_OUT=0, flush_pending=0.
  - PIXEL_READY, MEM_WE, MEM_CLK and FRAME_DONE are all 0.
  - RESET asserted mid-frame discards any partial word. No write is issued, and a write in progress is abandoned (MEM_WE and MEM_CLK drop in the next cycle).
- Outputs: all outputs are registers or pure decodes of the state register. No latches, and no combinational path from inputs to outputs except PIXEL_READY (state AND INTERFACE_EN).
- Handshake: a pixel transfers at a rising edge where PIXEL_VALID=1 and PIXEL_READY=1. The source holds RGB_IN/PIXEL_VALID until the transfer occurs.
- States and transitions:
  - IDLE: PIXEL_READY=0. If INTERFACE_EN=1, go to FIRST.
  - FIRST: PIXEL_READY=INTERFACE_EN.
    - On transfer: DATA_OUT[47:24]←RGB_IN, DATA_OUT[23:0]←0.
    - If FLUSH=1 in the same cycle: flush_pending←1 and go to WRITE; otherwise go to SECOND.
    - FLUSH=1 with no transfer: go to DONE and write nothing.
  - SECOND: PIXEL_READY=INTERFACE_EN.
    - On transfer: DATA_OUT[23:0]←RGB_IN and go to WRITE. flush_pending←FLUSH.
    - FLUSH=1 with no transfer: flush_pending←1, go to WRITE, and the low half stays 0.
  - WRITE: MEM_WE=1, MEM_CLK=0 (address/data setup cycle).
  - STROBE: MEM_WE=1, MEM_CLK=1.
  - NEXT: MEM_WE=0, MEM_CLK=0.
    - If MEM_ADDR==MAX_WORDS-1 or flush_pending=1: go to DONE.
    - Otherwise: MEM_ADDR←MEM_ADDR+1 and go to FIRST.
  - DONE: FRAME_DONE=1 for exactly one cycle. MEM_ADDR←0 and flush_pending←0, then go to IDLE.
- Hold rules:
  - INTERFACE_EN=0 in FIRST/SECOND holds the state and stored data with PIXEL_READY=0.
  - INTERFACE_EN has no effect in WRITE, STROBE, NEXT or DONE.
- Timing and throughput:
  - Minimum 5 cycles per word (2 accepts, WRITE, STROBE, NEXT).
  - PIXEL_READY=0 in WRITE, STROBE, NEXT and DONE.
  - DATA_OUT and MEM_ADDR are stable from WRITE through NEXT.
- Address: wraps only via DONE and never exceeds MAX_WORDS-1.
- FLUSH in IDLE, WRITE, STROBE, NEXT or DONE is ignored.

Decomposition:
- Shared package pixel_pkg holds:
  - State encoding constants: IDLE, FIRST, SECOND, WRITE, STROBE, NEXT, DONE.
  - PIXEL_W=24 and WORD_W=48.
  - Default ADDR_W/MAX_WORDS, shared with the reader.
- Single module; no sub-module needed.

Test Plan:
- Reset then INTERFACE_EN=1, pixels 0x112233 then 0x445566 back-to-back → one write with DATA_OUT=0x112233445566, MEM_ADDR=0, MEM_CLK high for exactly 1 cycle; PIXEL_READY returns 5 cycles after the first accept.
- Full frame of 64 pixels with MAX_WORDS=32 → 32 writes at addresses 0..31, FRAME_DONE pulses once after the write at address 31, MEM_ADDR=0, state IDLE.
- Odd pixel then FLUSH in SECOND (pixel 0xABCDEF at address 3) → write 0xABCDEF000000 to address 3, then FRAME_DONE, with no further writes.
- PIXEL_VALID and FLUSH in the same cycle in FIRST (0x010203) → immediate write 0x010203000000 and FRAME_DONE; FLUSH in FIRST with no valid → FRAME_DONE and no write.
- INTERFACE_EN dropped for 4 cycles in SECOND → PIXEL_READY=0 and the stored first pixel is preserved; on resume the packed word is correct.
- RESET asserted during STROBE at address 7 → next cycle MEM_WE=0, MEM_CLK=0, MEM_ADDR=0, no FRAME_DONE; the next frame starts at address 0.
